// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap controller: FSM states, trap kinds, interrupt codes
// and the side-effect command sent to the CSR file.
package trap_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] gpreg_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } trap_state_t;

  typedef enum logic [1:0] {
    KIND_EX,
    KIND_IRQ,
    KIND_RET
  } trap_kind_t;

  typedef enum logic [1:0] {
    CSR_EFF_NONE,
    CSR_EFF_EX,
    CSR_EFF_RET
  } csr_eff_t;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  typedef struct packed {
    csr_eff_t t;
    gpreg_t   src;
    gpreg_t   epc;
    gpreg_t   tval;
  } csr_effect;

  // mcause encoding for an interrupt: top bit marks it as asynchronous.
  function automatic gpreg_t irq_src(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle of commit-stage, CSR-file and fetch-redirect signals around the trap controller.
interface trap_ctrl_if;
  import trap_ctrl_pkg::*;

  logic       ex_valid;
  logic       ex_ready;
  logic [4:0] ex_cause;
  gpreg_t     ex_epc;
  gpreg_t     ex_tval;
  logic       ret_valid;
  logic       ret_ready;
  logic       irq_mei;
  logic       irq_msi;
  logic       irq_mti;
  logic       csr_mie_g;
  logic       csr_meie;
  logic       csr_msie;
  logic       csr_mtie;
  gpreg_t     csr_mtvec;
  gpreg_t     csr_mepc;
  gpreg_t     commit_pc;
  logic       pipe_idle;
  csr_effect  effect;
  logic       flush;
  logic       redir_valid;
  logic       redir_ready;
  gpreg_t     redir_pc;

  modport master (
    output ex_valid, ex_cause, ex_epc, ex_tval, ret_valid,
           irq_mei, irq_msi, irq_mti,
           csr_mie_g, csr_meie, csr_msie, csr_mtie, csr_mtvec, csr_mepc,
           commit_pc, pipe_idle, redir_ready,
    input  ex_ready, ret_ready, effect, flush, redir_valid, redir_pc
  );

  modport slave (
    input  ex_valid, ex_cause, ex_epc, ex_tval, ret_valid,
           irq_mei, irq_msi, irq_mti,
           csr_mie_g, csr_meie, csr_msie, csr_mtie, csr_mtvec, csr_mepc,
           commit_pc, pipe_idle, redir_ready,
    output ex_ready, ret_ready, effect, flush, redir_valid, redir_pc
  );

endinterface

// File: rtl/trap_ctrl_irq_prio.sv
// Interrupt enable masking and fixed-priority selection: MEI > MSI > MTI.
module irq_prio
  import trap_ctrl_pkg::*;
(
  input  logic       irq_mei,
  input  logic       irq_msi,
  input  logic       irq_mti,
  input  logic       csr_mie_g,
  input  logic       csr_meie,
  input  logic       csr_msie,
  input  logic       csr_mtie,
  output logic       pending,
  output logic [4:0] code
);

  logic mei_act;
  logic msi_act;
  logic mti_act;

  assign mei_act = irq_mei & csr_meie;
  assign msi_act = irq_msi & csr_msie;
  assign mti_act = irq_mti & csr_mtie;

  assign pending = csr_mie_g & (mei_act | msi_act | mti_act);
  assign code    = mei_act ? IRQ_MEI :
                   msi_act ? IRQ_MSI : IRQ_MTI;

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts exceptions, MRET and interrupts, drains the pipe,
// issues one CSR side-effect, then redirects fetch.
//
// state    | meaning
// IDLE     | ready for ex / ret / interrupt, no flush
// DRAIN    | trap latched, waiting for pipe_idle
// COMMIT   | one cycle, effect presented to CSR file
// REDIRECT | redir_valid held until fetch takes redir_pc
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  trap_state_t state;
  trap_kind_t  kind;
  gpreg_t      src_q;
  gpreg_t      epc_q;
  gpreg_t      tval_q;
  gpreg_t      redir_pc_q;
  csr_effect   effect_q;
  logic        redir_valid_q;
  logic        irq_pending;
  logic [4:0]  irq_code;

  irq_prio u_irq_prio (
    .irq_mei   (bus.irq_mei),
    .irq_msi   (bus.irq_msi),
    .irq_mti   (bus.irq_mti),
    .csr_mie_g (bus.csr_mie_g),
    .csr_meie  (bus.csr_meie),
    .csr_msie  (bus.csr_msie),
    .csr_mtie  (bus.csr_mtie),
    .pending   (irq_pending),
    .code      (irq_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      kind          <= KIND_EX;
      src_q         <= '0;
      epc_q         <= '0;
      tval_q        <= '0;
      redir_pc_q    <= '0;
      effect_q      <= '0;
      redir_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            kind   <= KIND_EX;
            src_q  <= {27'b0, bus.ex_cause};
            epc_q  <= bus.ex_epc;
            tval_q <= bus.ex_tval;
            state  <= DRAIN;
          end else if (bus.ret_valid) begin
            kind   <= KIND_RET;
            src_q  <= '0;
            epc_q  <= '0;
            tval_q <= '0;
            state  <= DRAIN;
          end else if (irq_pending) begin
            // Sources are captured here, so a line dropping later has no effect.
            kind   <= KIND_IRQ;
            src_q  <= irq_src(irq_code);
            epc_q  <= bus.commit_pc;
            tval_q <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.pipe_idle) begin
            effect_q.t    <= (kind == KIND_RET) ? CSR_EFF_RET : CSR_EFF_EX;
            effect_q.src  <= src_q;
            effect_q.epc  <= epc_q;
            effect_q.tval <= tval_q;
            state         <= COMMIT;
          end
        end
        COMMIT: begin
          effect_q      <= '0;
          redir_pc_q    <= (kind == KIND_RET) ? bus.csr_mepc : bus.csr_mtvec;
          redir_valid_q <= 1'b1;
          state         <= REDIRECT;
        end
        REDIRECT: begin
          if (bus.redir_ready) begin
            redir_valid_q <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ex_ready    = (state == IDLE);
  assign bus.ret_ready   = (state == IDLE);
  assign bus.flush       = (state != IDLE);
  assign bus.effect      = effect_q;
  assign bus.redir_valid = redir_valid_q;
  assign bus.redir_pc    = redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, randomized traffic
// against a transaction-level model, and hand sequences for arbitration and reset.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit         ex_v, ret_v, mei, msi, mti, meie, msie, mtie, mie_g;
    logic [4:0] cause;
    gpreg_t     ex_epc, ex_tval, commit_pc, mtvec, mepc;
    int         low, rstall;
    bit         acc;
    csr_eff_t   t;
    gpreg_t     src, epc, tval, redir;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t base();
    vec_t v;
    v.ex_v = 0; v.ret_v = 0; v.mei = 0; v.msi = 0; v.mti = 0;
    v.meie = 1; v.msie = 1; v.mtie = 1; v.mie_g = 1;
    v.cause = 5'd0; v.ex_epc = '0; v.ex_tval = '0; v.commit_pc = '0;
    v.mtvec = 32'h80; v.mepc = 32'h340;
    v.low = 0; v.rstall = 0;
    v.acc = 1; v.t = CSR_EFF_NONE; v.src = '0; v.epc = '0; v.tval = '0; v.redir = '0;
    return v;
  endfunction

  // Transaction-level reference: which request wins and what the CSR file must see.
  function automatic vec_t model(input vec_t v);
    int codes[3];
    bit lines[3];
    bit ens[3];
    codes = '{11, 3, 7};
    lines = '{v.mei, v.msi, v.mti};
    ens   = '{v.meie, v.msie, v.mtie};
    v.acc = 0; v.t = CSR_EFF_NONE; v.src = '0; v.epc = '0; v.tval = '0; v.redir = '0;
    if (v.ex_v) begin
      v.acc = 1; v.t = CSR_EFF_EX; v.src = 32'(v.cause);
      v.epc = v.ex_epc; v.tval = v.ex_tval; v.redir = v.mtvec;
    end else if (v.ret_v) begin
      v.acc = 1; v.t = CSR_EFF_RET; v.redir = v.mepc;
    end else if (v.mie_g) begin
      for (int i = 0; i < 3; i++) begin
        if (!v.acc && lines[i] && ens[i]) begin
          v.acc = 1; v.t = CSR_EFF_EX; v.src = 32'h8000_0000 + 32'(codes[i]);
          v.epc = v.commit_pc; v.redir = v.mtvec;
        end
      end
    end
    return v;
  endfunction

  // Called on a falling edge with the DUT idle; returns on a falling edge.
  task automatic run_vec(input vec_t v, input string nm);
    int        eff_cyc, eff_cnt, rv_cyc, rv_cnt, drain;
    bit        bad_flush, pc_moved, done;
    gpreg_t    pc0;
    csr_effect eff;
    eff_cyc = -1; eff_cnt = 0; rv_cyc = -1; rv_cnt = 0;
    bad_flush = 0; pc_moved = 0; done = 0; pc0 = '0; eff = '0;
    bus.ex_valid = v.ex_v; bus.ret_valid = v.ret_v;
    bus.irq_mei = v.mei; bus.irq_msi = v.msi; bus.irq_mti = v.mti;
    bus.csr_meie = v.meie; bus.csr_msie = v.msie; bus.csr_mtie = v.mtie;
    bus.csr_mie_g = v.mie_g; bus.ex_cause = v.cause; bus.ex_epc = v.ex_epc;
    bus.ex_tval = v.ex_tval; bus.commit_pc = v.commit_pc;
    bus.csr_mtvec = v.mtvec; bus.csr_mepc = v.mepc;
    bus.pipe_idle = (v.low == 0); bus.redir_ready = 1'b0;
    chk({nm, ".idle_ready"}, {bus.ex_ready, bus.ret_ready, bus.flush}, 3'b110);
    @(posedge clk); @(negedge clk);
    bus.ex_valid = 0; bus.ret_valid = 0;
    bus.irq_mei = 0; bus.irq_msi = 0; bus.irq_mti = 0;
    if (!v.acc) begin
      chk({nm, ".no_accept"}, bus.flush, 1'b0);
      return;
    end
    for (int i = 1; i < 100 && !done; i++) begin
      bus.pipe_idle = (i >= v.low);
      if (!bus.flush || bus.ex_ready || bus.ret_ready) bad_flush = 1;
      if (bus.effect.t != CSR_EFF_NONE) begin
        eff_cnt++;
        if (eff_cnt == 1) begin
          eff_cyc = i;
          eff = bus.effect;
          if (eff.t == CSR_EFF_EX) bus.csr_mie_g = 1'b0;
        end
      end
      if (bus.redir_valid) begin
        if (rv_cnt == 0) begin
          rv_cyc = i;
          pc0 = bus.redir_pc;
        end else if (bus.redir_pc !== pc0) pc_moved = 1;
        bus.redir_ready = (rv_cnt >= v.rstall);
        rv_cnt++;
        done = bus.redir_ready;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.redir_ready = 1'b0;
    chk({nm, ".completed"}, done, 1'b1);
    drain = (v.low <= 1) ? 1 : v.low;
    chk({nm, ".busy_flush"}, bad_flush, 1'b0);
    chk({nm, ".effect_cycle"}, eff_cyc, drain + 1);
    chk({nm, ".effect_count"}, eff_cnt, 1);
    chk({nm, ".effect_t"}, eff.t, v.t);
    if (v.t != CSR_EFF_RET) begin
      chk({nm, ".src"}, eff.src, v.src);
      chk({nm, ".epc"}, eff.epc, v.epc);
      chk({nm, ".tval"}, eff.tval, v.tval);
    end
    chk({nm, ".redir_cycle"}, rv_cyc, drain + 2);
    chk({nm, ".redir_pc"}, pc0, v.redir);
    chk({nm, ".redir_stable"}, pc_moved, 1'b0);
    chk({nm, ".redir_hold"}, rv_cnt, v.rstall + 1);
    chk({nm, ".back_idle"}, {bus.flush, bus.redir_valid, bus.ex_ready}, 3'b001);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    int  n_ex, k;
    bit  bad, found;

    bus.ex_valid = 0; bus.ret_valid = 0; bus.ex_cause = '0; bus.ex_epc = '0;
    bus.ex_tval = '0; bus.irq_mei = 0; bus.irq_msi = 0; bus.irq_mti = 0;
    bus.csr_mie_g = 0; bus.csr_meie = 0; bus.csr_msie = 0; bus.csr_mtie = 0;
    bus.csr_mtvec = '0; bus.csr_mepc = '0; bus.commit_pc = '0;
    bus.pipe_idle = 1; bus.redir_ready = 0;

    #12;
    chk("reset.outputs",
        {bus.ex_ready, bus.ret_ready, bus.flush, bus.redir_valid, 2'(bus.effect.t)}, 6'b110000);
    chk("reset.redir_pc", bus.redir_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    v = base(); v.ex_v = 1; v.cause = 5'd2; v.ex_epc = 32'h100; v.ex_tval = 32'hDEAD;
    v.t = CSR_EFF_EX; v.src = 32'h2; v.epc = 32'h100; v.tval = 32'hDEAD; v.redir = 32'h80;
    tbl.push_back(v);
    v = base(); v.mti = 1; v.mei = 1; v.commit_pc = 32'h200; v.mtvec = 32'h1000;
    v.t = CSR_EFF_EX; v.src = 32'h8000000B; v.epc = 32'h200; v.redir = 32'h1000;
    tbl.push_back(v);
    v = base(); v.mti = 1; v.mei = 1; v.mie_g = 0; v.acc = 0;
    tbl.push_back(v);
    v = base(); v.ret_v = 1; v.mepc = 32'h340; v.low = 4; v.rstall = 2;
    v.t = CSR_EFF_RET; v.redir = 32'h340;
    tbl.push_back(v);
    v = base(); v.mei = 1; v.msi = 1; v.mti = 1; v.meie = 0; v.commit_pc = 32'h44;
    v.low = 2; v.t = CSR_EFF_EX; v.src = 32'h80000003; v.epc = 32'h44; v.redir = 32'h80;
    tbl.push_back(v);
    v = base(); v.mti = 1; v.commit_pc = 32'h88; v.mtvec = 32'h400; v.rstall = 1;
    v.t = CSR_EFF_EX; v.src = 32'h80000007; v.epc = 32'h88; v.redir = 32'h400;
    tbl.push_back(v);
    v = base(); v.ex_v = 1; v.mei = 1; v.cause = 5'd5; v.ex_epc = 32'h600; v.ex_tval = 32'h7;
    v.t = CSR_EFF_EX; v.src = 32'h5; v.epc = 32'h600; v.tval = 32'h7; v.redir = 32'h80;
    tbl.push_back(v);
    v = base(); v.ret_v = 1; v.msi = 1; v.mepc = 32'h900;
    v.t = CSR_EFF_RET; v.redir = 32'h900;
    tbl.push_back(v);
    v = base(); v.mei = 1; v.msi = 1; v.mti = 1; v.meie = 0; v.msie = 0; v.mtie = 0; v.acc = 0;
    tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    for (int n = 0; n < 30; n++) begin
      int r;
      v = base();
      r = $urandom_range(0, 9);
      v.ex_v = (r < 3); v.ret_v = (r >= 2 && r < 5);
      v.mei = 1'($urandom); v.msi = 1'($urandom); v.mti = 1'($urandom);
      v.meie = 1'($urandom); v.msie = 1'($urandom); v.mtie = 1'($urandom);
      v.mie_g = ($urandom_range(0, 3) != 0);
      v.cause = 5'($urandom); v.ex_epc = $urandom & ~32'h3; v.ex_tval = $urandom;
      v.commit_pc = $urandom & ~32'h3; v.mtvec = ($urandom & ~32'h3) | 32'h4;
      v.mepc = ($urandom & ~32'h3) | 32'h4;
      v.low = $urandom_range(0, 5); v.rstall = $urandom_range(0, 3);
      run_vec(model(v), $sformatf("rnd%0d", n));
    end

    // Simultaneous ex and ret: ex wins, ret waits for IDLE and is then taken.
    bus.ex_valid = 1; bus.ret_valid = 1; bus.ex_cause = 5'd4; bus.ex_epc = 32'h44;
    bus.csr_mtvec = 32'h80; bus.csr_mepc = 32'h340; bus.pipe_idle = 1; bus.redir_ready = 1;
    @(posedge clk); @(negedge clk);
    bus.ex_valid = 0;
    n_ex = 0; bad = 0; k = 0;
    while (bus.flush && k < 20) begin
      if (bus.ret_ready) bad = 1;
      if (bus.effect.t == CSR_EFF_EX) n_ex++;
      if (bus.effect.t == CSR_EFF_RET) bad = 1;
      @(posedge clk); @(negedge clk);
      k++;
    end
    chk("arb.ret_held_off", bad, 1'b0);
    chk("arb.one_ex_effect", n_ex, 1);
    chk("arb.ret_ready_idle", {bus.ret_ready, bus.flush}, 2'b10);
    @(posedge clk); @(negedge clk);
    bus.ret_valid = 0;
    chk("arb.ret_accepted", bus.flush, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.effect.t == CSR_EFF_RET) found = 1;
      @(posedge clk); @(negedge clk);
    end
    chk("arb.ret_effect", found, 1'b1);
    for (int i = 0; i < 10 && bus.flush; i++) begin
      @(posedge clk); @(negedge clk);
    end
    bus.redir_ready = 0;

    // Reset while draining discards the trap.
    bus.ex_valid = 1; bus.ex_cause = 5'd1; bus.pipe_idle = 0; bus.csr_mtvec = 32'h120;
    @(posedge clk); @(negedge clk);
    bus.ex_valid = 0;
    chk("rst.in_drain", bus.flush, 1'b1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.async_outputs",
        {bus.flush, bus.redir_valid, 2'(bus.effect.t), bus.ex_ready}, 5'b00001);
    chk("rst.redir_pc", bus.redir_pc, 32'h0);
    #3;
    rst = 1'b0;
    bus.pipe_idle = 1; bus.redir_ready = 1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.flush || bus.redir_valid || bus.effect.t != CSR_EFF_NONE) bad = 1;
    end
    chk("rst.no_partial_effect", bad, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk  in  1  clock; all state updates on posedge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 ex_valid / ex_ready  in/out  1/1  synchronous-exception request handshake from commit stage.
REQ-004 ex_cause  in  5  exception code; ex_epc, ex_tval  in  gpreg  faulting PC, trap value.
REQ-005 ret_valid / ret_ready  in/out  1/1  MRET request handshake from commit stage.
REQ-006 irq_mei, irq_msi, irq_mti  in  1 each  level-sensitive external/software/timer interrupt lines.
REQ-007 csr_mie_g, csr_meie, csr_msie, csr_mtie  in  1 each  global and per-source enables from CSR file.
REQ-008 csr_mtvec, csr_mepc  in  gpreg  current trap vector and exception PC from CSR file.
REQ-009 commit_pc  in  gpreg  PC of next instruction to commit; becomes mepc on interrupt.
REQ-010 pipe_idle  in  1  high when no instruction is in flight past decode.
REQ-011 effect  out  csr_effect  side-effect command to CSR file (t, src, epc, tval).
REQ-012 flush  out  1  pipeline kill, high while state != IDLE.
REQ-013 redir_valid / redir_ready  out/in  1/1  PC redirect handshake to fetch; redir_pc  out  gpreg  target.

Function
REQ-014 States: IDLE, DRAIN, COMMIT, REDIRECT.
REQ-015 IDLE: ex_ready = ret_ready = 1; all other states: 0; requests outside IDLE are not accepted.
REQ-016 Priority in IDLE, same cycle: ex_valid > ret_valid > pending interrupt; loser stays un-accepted.
REQ-017 Interrupt pending = csr_mie_g & ((irq_mei&csr_meie) | (irq_msi&csr_msie) | (irq_mti&csr_mtie)); source priority MEI(11) > MSI(3) > MTI(7).
REQ-018 On accept: latch kind (EX/IRQ/RET), src, epc, tval; go DRAIN.
REQ-019 Latched src: exception = {27'b0, ex_cause}; interrupt = bit31 set | code; epc = ex_epc or commit_pc; tval = ex_tval or 0.
REQ-020 DRAIN: stay until pipe_idle = 1, then COMMIT; pipe_idle already high gives one DRAIN cycle.
REQ-021 COMMIT: exactly one cycle; effect.t = CSR_EFF_EX (EX, IRQ) or CSR_EFF_RET (RET), fields from latch; latch redir_pc = csr_mtvec (EX/IRQ) or csr_mepc (RET); go REDIRECT.
REQ-022 effect.t = CSR_EFF_NONE in every state except COMMIT.
REQ-023 REDIRECT: redir_valid = 1, redir_pc stable until redir_ready; on handshake go IDLE.
REQ-024 Accept-to-effect latency = 1 + DRAIN cycles; minimum accept-to-redir_valid = 3 cycles.
REQ-025 Interrupt line dropping after accept does not cancel the trap.
REQ-026 Interrupt masked (csr_mie_g = 0) on the cycle after COMMIT; no back-to-back re-entry before handler runs.
REQ-027 flush = (state != IDLE), combinational from state.

Reset
REQ-028 rst asserted at any time: state = IDLE, latches cleared, effect.t = CSR_EFF_NONE, redir_valid = 0, flush = 0; in-progress trap discarded, no partial effect.
REQ-029 Outputs after reset: ex_ready = ret_ready = 1, redir_pc = 0.

Structure
REQ-030 State enum trap_state_t, trap kind enum, interrupt code constants (IRQ_MSI = 3, IRQ_MTI = 7, IRQ_MEI = 11) are in types.sv, alongside csr_effect.
REQ-031 One sub-module irq_prio: combinational enables-and-priority encoder, outputs pending flag and 5-bit code.

Verification
REQ-032 ex_valid, cause 2, epc 0x100, tval 0xDEAD, pipe_idle = 1, mtvec 0x80 -> effect EX src 2 epc 0x100 for one cycle, redir_pc 0x80 at cycle 3.
REQ-033 ex_valid and ret_valid same cycle -> only ex accepted, ret_ready = 0 until IDLE returns; one EX effect.
REQ-034 irq_mti + irq_mei, all enabled, commit_pc 0x200 -> src 0x8000000B, epc 0x200; csr_mie_g = 0 -> no accept.
REQ-035 ret_valid, mepc 0x340, pipe_idle low 4 cycles -> DRAIN 4 cycles, RET effect, redir_pc 0x340; redir_ready low 2 cycles -> redir_valid held, pc stable.
REQ-036 rst asserted in DRAIN -> IDLE next, no effect issued, flush = 0, redir_valid = 0.
